// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch stage with prefetch queue and redirect
// Optional delivered-instruction counter on fetch_count when FETCH_STAT_EN is defined.
module riscv_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_STAT_EN
  , output logic [15:0]     fetch_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [15:0]       ins_mem_q [DEPTH];
  logic [15:0]       ins_mem_d [DEPTH];
  logic              push;
  logic              pop;
  logic              outstanding;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pc_mem_d    = pc_mem_q;
    ins_mem_d   = ins_mem_q;
    outstanding = 1'b0;

    // Redirect wins over both queue operations.
    push = (state_q == S_WAIT) && imem_rvalid && !redirect;
    pop  = (count_q != '0) && instr_ready && !redirect;

    if (push) begin
      pc_mem_d[wr_ptr_q]  = fetch_pc_q - ADDR_W'(1);
      ins_mem_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    unique case (state_q)
      S_IDLE: begin
        if (count_q < CNT_W'(DEPTH)) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Post-push occupancy decides whether another slot can be claimed.
        if (imem_rvalid) state_d = (count_d < CNT_W'(DEPTH)) ? S_REQ : S_IDLE;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      outstanding = ((state_q == S_WAIT) && !imem_rvalid) ||
                    ((state_q == S_REQ)  && imem_gnt)     ||
                    ((state_q == S_DROP) && !imem_rvalid);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      state_d    = outstanding ? S_DROP : S_REQ;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  // An empty queue presents a NOP at pc 0 rather than stale storage.
  assign instr       = instr_valid ? ins_mem_q[rd_ptr_q] : 16'h0000;
  assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : '0;

`ifdef FETCH_STAT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (pop) fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fetch_count_q <= '0;
    else        fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - directed self-checking bench for riscv_fetch_unit
// Also covers fetch_count when FETCH_STAT_EN is defined.
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
`ifdef FETCH_STAT_EN
  logic [15:0] fetch_count;
`endif

  logic        req2, gnt2, rv2_q = 1'b0, valid2, ready2, redirect2;
  logic [7:0]  addr2, pc2, rpc2;
  logic [15:0] rd2_q = 16'h0, instr2;

  logic        gnt_en, hold, inject;
  logic        rv_q = 1'b0, pend_q = 1'b0;
  logic [7:0]  pend_a = 8'h0;
  logic [15:0] rd_q = 16'h0;

  logic [7:0]  glog [128];
  logic [7:0]  g2log [128];
  logic [7:0]  plog_pc [128];
  logic [15:0] plog_in [128];
  int          gn = 0, g2n = 0, pn = 0;
  int          passed = 0, total = 0;

  always #5 clk = ~clk;

  riscv_fetch_unit #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_STAT_EN
    , .fetch_count(fetch_count)
`endif
  );

`ifdef FETCH_STAT_EN
  logic [15:0] fetch_count2;
`endif
  riscv_fetch_unit #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hFE)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rv2_q), .imem_rdata(rd2_q),
    .instr(instr2), .instr_pc(pc2), .instr_valid(valid2),
    .instr_ready(ready2), .redirect(redirect2), .redirect_pc(rpc2)
`ifdef FETCH_STAT_EN
    , .fetch_count(fetch_count2)
`endif
  );

  function automatic logic [15:0] word(input logic [7:0] a);
    word = {8'hC3, a};
  endfunction

  // Memory model: grants when enabled, answers one cycle after grant unless held.
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = rv_q | inject;
  assign imem_rdata  = rd_q;

  always @(posedge clk) begin
    rv_q <= 1'b0;
    if (imem_req && imem_gnt) begin
      if (gn < 128) glog[gn] <= imem_addr;
      gn <= gn + 1;
      if (hold) begin
        pend_q <= 1'b1;
        pend_a <= imem_addr;
      end else begin
        rv_q <= 1'b1;
        rd_q <= word(imem_addr);
      end
    end else if (pend_q && !hold) begin
      rv_q   <= 1'b1;
      rd_q   <= word(pend_a);
      pend_q <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset && instr_valid && instr_ready && !redirect) begin
      if (pn < 128) begin
        plog_pc[pn] <= instr_pc;
        plog_in[pn] <= instr;
      end
      pn <= pn + 1;
    end
  end

  assign gnt2 = req2;
  always @(posedge clk) begin
    rv2_q <= req2 && gnt2;
    rd2_q <= word(addr2);
    if (req2 && gnt2) begin
      if (g2n < 128) g2log[g2n] <= addr2;
      g2n <= g2n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int lim);
    int k = 0;
    while (!imem_req && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("wait_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_pops(input int target, input int lim);
    int k = 0;
    while (pn < target && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("wait_pops", {31'd0, pn >= target}, 32'd1);
  endtask

  initial begin
    int e, pn0, pnr, gr, pnz;
    reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    gnt_en = 1'b1; hold = 1'b0; inject = 1'b0;
    ready2 = 1'b1; redirect2 = 1'b0; rpc2 = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'h00);
    chk("rst_instr", {16'd0, instr}, 32'h0000);
    chk("rst_pc", {24'd0, instr_pc}, 32'h00);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_STAT_EN
    chk("rst_count", {16'd0, fetch_count}, 32'd0);
`endif

    // First request one cycle after release, valid two cycles after that.
    reset = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {24'd0, imem_addr}, 32'h00);
    @(negedge clk);
    chk("valid_n1", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("valid_n2", {31'd0, instr_valid}, 32'd1);
    chk("head_pc", {24'd0, instr_pc}, 32'h00);
    chk("head_instr", {16'd0, instr}, {16'd0, word(8'h00)});

    // Ready low: exactly DEPTH fetches, then the request line stays low.
    repeat (16) @(negedge clk);
    chk("full_grants", gn, 32'd4);
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_head", {24'd0, instr_pc}, 32'h00);
    for (int i = 0; i < 4; i++) chk("full_addr", {24'd0, glog[i]}, i);

    instr_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("resume_addr", {24'd0, glog[4]}, 32'h04);
    chk("resume_pops", {31'd0, pn >= 8}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("seq_pc", {24'd0, plog_pc[i]}, i);
      chk("seq_instr", {16'd0, plog_in[i]}, {16'd0, word(8'(i))});
    end

    // Grant withheld for three cycles.
    gnt_en = 1'b0;
    wait_req(10);
    e = gn;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", {24'd0, imem_addr}, e);
      @(negedge clk);
    end
    pn0 = pn;
    gnt_en = 1'b1;
    @(negedge clk);
    chk("stall_grant", gn, e + 1);
    chk("stall_gaddr", {24'd0, glog[e]}, e);
    repeat (2) @(negedge clk);
    chk("stall_push", pn, pn0 + 1);
    chk("stall_ppc", {24'd0, plog_pc[pn0]}, e);
    chk("stall_pin", {16'd0, plog_in[pn0]}, {16'd0, word(8'(e))});

    // Redirect while a response is outstanding.
    instr_ready = 1'b0;
    hold = 1'b1;
    wait_req(10);
    @(negedge clk);
    chk("pre_flush_valid", {31'd0, instr_valid}, 32'd1);
    pnr = pn;
    redirect = 1'b1;
    redirect_pc = 8'h20;
    @(negedge clk);
    redirect = 1'b0;
    chk("flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    gr = gn;
    hold = 1'b0;
    repeat (2) @(negedge clk);
    instr_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("redir_addr", {24'd0, glog[gr]}, 32'h20);
    chk("redir_pc", {24'd0, plog_pc[pnr]}, 32'h20);
    chk("redir_instr", {16'd0, plog_in[pnr]}, {16'd0, word(8'h20)});

    // Reset mid-WAIT, then a stale response arriving after release.
    hold = 1'b1;
    wait_req(10);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_addr", {24'd0, imem_addr}, 32'h00);
    chk("mid_rst_instr", {16'd0, instr}, 32'h0000);
    chk("mid_rst_pc", {24'd0, instr_pc}, 32'h00);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_STAT_EN
    chk("mid_rst_count", {16'd0, fetch_count}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hold = 1'b0;
    pnz = pn;
    wait_pops(pnz + 5, 40);
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 8'h40;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_pc", {24'd0, plog_pc[pnz + i]}, i);
      chk("post_rst_instr", {16'd0, plog_in[pnz + i]}, {16'd0, word(8'(i))});
    end
    @(negedge clk);
    redirect = 1'b0;
    instr_ready = 1'b1;
    pnr = pn;
    wait_pops(pnr + 2, 40);
    instr_ready = 1'b0;
    chk("redir2_pc0", {24'd0, plog_pc[pnr]}, 32'h40);
    chk("redir2_pc1", {24'd0, plog_pc[pnr + 1]}, 32'h41);
`ifdef FETCH_STAT_EN
    chk("stat_count", {16'd0, fetch_count}, 32'd7);
    @(negedge clk);
    chk("stat_hold", {16'd0, fetch_count}, 32'd7);
`endif

    // Second instance started at FE wraps through zero.
    chk("wrap_a0", {24'd0, g2log[0]}, 32'hFE);
    chk("wrap_a1", {24'd0, g2log[1]}, 32'hFF);
    chk("wrap_a2", {24'd0, g2log[2]}, 32'h00);
    chk("wrap_a3", {24'd0, g2log[3]}, 32'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Instruction fetch stage directly upstream of `simple_riscv`. It generates sequential instruction addresses, fetches 16-bit instructions from the instruction memory over a request/grant/response handshake, and buffers them in a small prefetch queue. It presents one instruction per cycle to the core's `instruction` input with a valid/ready handshake, and supports redirect (flush and restart from a new PC).

## Interface
- `ADDR_W`, 8, instruction address width (word address, one 16-bit instruction per word)
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2
- `RESET_PC`, 0, first fetch address after reset
- `clk`  input  1  clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `imem_req`  output  1  fetch request
- `imem_addr`  output  ADDR_W  fetch address
- `imem_gnt`  input  1  request accepted this cycle
- `imem_rvalid`  input  1  response data valid
- `imem_rdata`  input  16  instruction word
- `instr`  output  16  head instruction to core
- `instr_pc`  output  ADDR_W  address of `instr`
- `instr_valid`  output  1  queue non-empty
- `instr_ready`  input  1  core consumes head this cycle
- `redirect`  input  1  flush and restart fetch
- `redirect_pc`  input  ADDR_W  restart address
- `fetch_count`  output  16  delivered-instruction counter (only with `FETCH_STAT_EN`)

## Operation
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=16'h0000 (NOP), `instr_pc`=0, `instr_valid`=0, `fetch_count`=0, queue empty, FSM=IDLE, fetch PC=`RESET_PC`.
- Queue entries are {pc, instr}. Push on accepted response, pop on `instr_valid && instr_ready`. Push and pop in the same cycle are both allowed.
- Credit rule: a request issues only if registered `count + outstanding < DEPTH`, so the queue never overflows. At most 1 request is outstanding.
- FSM:
  - IDLE: `imem_req`=0. Moves to REQ when the credit rule holds.
  - REQ: `imem_req`=1, `imem_addr`=fetch PC. On `imem_gnt`, fetch PC increments and the FSM moves to WAIT.
  - WAIT: on `imem_rvalid`, push the response, then go to REQ if credit allows, else IDLE.
  - DROP: wait for `imem_rvalid`, discard the data, then go to REQ.
- PC increment is modulo 2^ADDR_W; it wraps from all-ones to 0.
- Redirect (highest priority, any state):
  - Flush the queue; `instr_valid`=0 the next cycle. Fetch PC is set to `redirect_pc`.
  - If a request is outstanding (WAIT, or REQ with `imem_gnt` in the same cycle), go to DROP. Otherwise go to REQ.
  - `redirect` in the same cycle as `imem_rvalid`: the response is discarded and the FSM goes to REQ.
  - `redirect` in the same cycle as a pop: the pop is ignored and the flush takes effect.
- `imem_rvalid` outside WAIT/DROP is ignored.
- `reset` asserted mid-transaction returns all state to reset values immediately. Any later stale `imem_rvalid` is ignored by IDLE.

## Timing
- `imem_addr` is stable while `imem_req`=1 and `imem_gnt`=0. The only exception is redirect, which may withdraw or retarget an ungranted request.
- First `imem_req` is in the first cycle after `reset` deasserts (IDLE→REQ on that edge).
- Latency with `imem_gnt` granted immediately and `imem_rvalid` one cycle later:
  - request at cycle N, response at N+1, `instr_valid` at N+2.
  - Throughput is one instruction per 2 cycles (single outstanding).
- `instr`, `instr_pc`, `instr_valid` are registered queue-head outputs with no combinational path from `imem_*`. `instr_ready` affects only next-cycle state.

## Configuration
- `FETCH_STAT_EN` defined:
  - `fetch_count` is a 16-bit counter, incremented on every pop and wrapping at 16'hFFFF→0.
  - It is cleared by reset and not cleared by redirect.
- `FETCH_STAT_EN` undefined: the port `fetch_count` and its logic are absent.

## Test plan
- Reset release, memory always grants with rvalid one cycle later, `instr_ready`=1 → fetch addresses 0,1,2,…; `instr_pc`/`instr` match memory words; `instr_valid` first high 2 cycles after the first request.
- `instr_ready`=0 with DEPTH=4 → exactly 4 entries fetched, `imem_req` then stays 0. Release ready → fetching resumes at address 4 and no instruction is lost.
- `imem_gnt` held low 3 cycles → `imem_req`=1 and `imem_addr` constant throughout; one push after the grant.
- `redirect` with `redirect_pc`=8'h20 while in WAIT → queue flushed, the stale response dropped, next request address 8'h20, next `instr_pc`=8'h20.
- `RESET_PC`=8'hFE → fetch addresses FE, FF, 00, 01.
- With `FETCH_STAT_EN`: deliver 5 instructions, redirect, deliver 2 → `fetch_count`=7. Assert `reset` mid-WAIT → all outputs return to reset values.
